btn_event_ctrl: RTL

Button input controller for the 8-bit calculator front panel.
- Samples NUM_BTN raw pushbuttons on a divided-down tick and filters each one with a per-button stability counter.
- Turns each debounced press into a pending event.
- Schedules pending events round-robin onto a single valid/ready channel consumed by the calculator control FSM, so simultaneous presses are serialized fairly and none are lost silently.

---
 rtl/btn_event_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/btn_event_ctrl.sv
// Pushbutton controller: synchronize, debounce on a slow tick, and
// queue press events onto a round-robin valid/ready channel.
// Ports: clk, rst (async, active-high), btn_in (raw buttons),
//   btn_level (debounced levels), evt_valid/evt_id/evt_ready
//   (event channel), evt_drop (pulse when a press is lost).
module btn_event_ctrl #(
  parameter int NUM_BTN      = 5,
  parameter int TICK_DIV     = 65536,
  parameter int STABLE_TICKS = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  output logic [2:0]         evt_id,
  input  logic               evt_ready,
  output logic               evt_drop
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;
  logic [TW-1:0]      tcnt;
  logic               tick;
  logic [CW-1:0]      cnt     [NUM_BTN];
  logic [CW-1:0]      cnt_nxt [NUM_BTN];
  logic [NUM_BTN-1:0] level_nxt;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pending_nxt;
  logic [NUM_BTN-1:0] clr;
  logic [2:0]         last;
  logic [2:0]         win;
  logic               found;
  logic               load;
  logic               take;
  logic               drop_nxt;
  int                 idx;

  assign tick = (tcnt == TW'(TICK_DIV - 1));

  always_comb begin
    level_nxt = btn_level;
    press     = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (s2[i] == btn_level[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CW'(STABLE_TICKS - 1)) begin
          level_nxt[i] = s2[i];
          cnt_nxt[i]   = '0;
          press[i]     = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Round-robin: first pending bit strictly after the last grant.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx = (int'(last) + k) % NUM_BTN;
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  // A press on the bit being granted this cycle re-arms it cleanly,
  // so only presses on a bit that stays pending are dropped.
  always_comb begin
    load        = !evt_valid || evt_ready;
    take        = load && found;
    clr         = take ? (NUM_BTN'(1) << win) : '0;
    pending_nxt = (pending & ~clr) | press;
    drop_nxt    = |(press & pending & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      tcnt      <= '0;
      btn_level <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
      pending   <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_drop  <= 1'b0;
      last      <= 3'(NUM_BTN - 1);
    end else begin
      s1        <= btn_in;
      s2        <= s1;
      tcnt      <= tick ? '0 : tcnt + 1'b1;
      btn_level <= level_nxt;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= cnt_nxt[i];
      pending   <= pending_nxt;
      evt_drop  <= drop_nxt;
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_id <= win;
          last   <= win;
        end
      end
    end
  end

endmodule
